// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decoded control through ID/EX, EX/MEM and MEM/WB,
// detects load-use hazards, inserts bubbles and resolves branch/jump flushes.
// Ports: clk/rst_n; ID decoder bundle + id_valid, id_rs/rt/rd, mem_zero in;
// per-stage EX/MEM/WB control out; hold_pc, flush_ifid, jump_taken,
// branch_taken and the saturating stall_count out.
module ctrl_pipe #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic                   regdst,
    input  logic                   jump,
    input  logic                   branch,
    input  logic                   memread,
    input  logic                   memtoreg,
    input  logic                   memwrite,
    input  logic                   alusrc,
    input  logic                   regwrite,
    input  logic [1:0]             aluop,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic [4:0]             id_rd,
    input  logic                   mem_zero,
    output logic                   ex_valid,
    output logic                   ex_regdst,
    output logic                   ex_alusrc,
    output logic                   ex_memread,
    output logic [1:0]             ex_aluop,
    output logic [4:0]             ex_wreg,
    output logic                   mem_valid,
    output logic                   mem_memread,
    output logic                   mem_memwrite,
    output logic                   mem_branch,
    output logic [4:0]             mem_wreg,
    output logic                   wb_regwrite,
    output logic                   wb_memtoreg,
    output logic [4:0]             wb_wreg,
    output logic                   hold_pc,
    output logic                   flush_ifid,
    output logic                   jump_taken,
    output logic                   branch_taken,
    output logic [STALL_CNT_W-1:0] stall_count
);

    // ID/EX state not exported directly
    logic       ex_memwrite;
    logic       ex_branch;
    logic       ex_memtoreg;
    logic       ex_regwrite;
    logic [4:0] ex_rt;
    logic [4:0] ex_rd;

    // EX/MEM state carried on to WB
    logic       mem_memtoreg;
    logic       mem_regwrite;

    logic load_use;
    logic stall;
    logic idex_bubble;

    assign branch_taken = mem_valid & mem_branch & mem_zero;

    // ex_rt of zero is never a real destination, so it cannot hazard
    assign load_use = id_valid & ex_valid & ex_memread
                    & (ex_rt != 5'd0)
                    & ((ex_rt == id_rs) | (ex_rt == id_rt));

    // a flush in the same cycle makes the stall pointless
    assign stall = load_use & ~branch_taken;

    // rst_n gate keeps the redirect quiet while reset is held
    assign jump_taken = rst_n & id_valid & jump
                      & ~stall & ~branch_taken;

    assign hold_pc     = stall;
    assign flush_ifid  = branch_taken | jump_taken;
    assign ex_wreg     = ex_regdst ? ex_rd : ex_rt;
    assign idex_bubble = branch_taken | stall | ~id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_regdst   <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_memread  <= 1'b0;
            ex_aluop    <= 2'b00;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_rt       <= 5'd0;
            ex_rd       <= 5'd0;
        end else if (idex_bubble) begin
            ex_valid    <= 1'b0;
            ex_regdst   <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_memread  <= 1'b0;
            ex_aluop    <= 2'b00;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_rt       <= 5'd0;
            ex_rd       <= 5'd0;
        end else begin
            ex_valid    <= 1'b1;
            ex_regdst   <= regdst;
            ex_alusrc   <= alusrc;
            ex_memread  <= memread;
            ex_aluop    <= aluop;
            ex_memwrite <= memwrite;
            ex_branch   <= branch;
            ex_memtoreg <= memtoreg;
            ex_regwrite <= regwrite;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid    <= 1'b0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            mem_branch   <= 1'b0;
            mem_memtoreg <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_wreg     <= 5'd0;
        end else if (branch_taken) begin
            mem_valid    <= 1'b0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            mem_branch   <= 1'b0;
            mem_memtoreg <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_wreg     <= 5'd0;
        end else begin
            mem_valid    <= ex_valid;
            mem_memread  <= ex_memread;
            mem_memwrite <= ex_memwrite;
            mem_branch   <= ex_branch;
            mem_memtoreg <= ex_memtoreg;
            mem_regwrite <= ex_regwrite;
            mem_wreg     <= ex_wreg;
        end
    end

    // the branch in MEM itself always completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_regwrite <= 1'b0;
            wb_memtoreg <= 1'b0;
            wb_wreg     <= 5'd0;
        end else begin
            wb_regwrite <= mem_regwrite;
            wb_memtoreg <= mem_memtoreg;
            wb_wreg     <= mem_wreg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && !(&stall_count)) begin
            stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed vector table plus reset and
// saturation sequences for ctrl_pipe.
module tb_ctrl_pipe;

    localparam int K_B    = 0;
    localparam int K_ADD  = 1;
    localparam int K_LW   = 2;
    localparam int K_SW   = 3;
    localparam int K_ADDI = 4;
    localparam int K_BEQ  = 5;
    localparam int K_J    = 6;

    logic clk;
    logic rst_n;
    logic id_valid;
    logic regdst, jump, branch, memread;
    logic memtoreg, memwrite, alusrc, regwrite;
    logic [1:0] aluop;
    logic [4:0] id_rs, id_rt, id_rd;
    logic mem_zero;
    logic ex_valid, ex_regdst, ex_alusrc, ex_memread;
    logic [1:0] ex_aluop;
    logic [4:0] ex_wreg;
    logic mem_valid, mem_memread, mem_memwrite, mem_branch;
    logic [4:0] mem_wreg;
    logic wb_regwrite, wb_memtoreg;
    logic [4:0] wb_wreg;
    logic hold_pc, flush_ifid, jump_taken, branch_taken;
    logic [1:0] stall_count;

    ctrl_pipe #(.STALL_CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .regdst(regdst), .jump(jump), .branch(branch),
        .memread(memread), .memtoreg(memtoreg),
        .memwrite(memwrite), .alusrc(alusrc),
        .regwrite(regwrite), .aluop(aluop),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .mem_zero(mem_zero),
        .ex_valid(ex_valid), .ex_regdst(ex_regdst),
        .ex_alusrc(ex_alusrc), .ex_memread(ex_memread),
        .ex_aluop(ex_aluop), .ex_wreg(ex_wreg),
        .mem_valid(mem_valid), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .mem_branch(mem_branch),
        .mem_wreg(mem_wreg),
        .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
        .wb_wreg(wb_wreg),
        .hold_pc(hold_pc), .flush_ifid(flush_ifid),
        .jump_taken(jump_taken), .branch_taken(branch_taken),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] ex_g;
    logic [8:0]  mem_g;
    logic [6:0]  wb_g;
    logic [3:0]  ctl_g;
    logic [32:0] all_g;
    assign ex_g  = {ex_valid, ex_regdst, ex_alusrc,
                    ex_memread, ex_aluop, ex_wreg};
    assign mem_g = {mem_valid, mem_memread, mem_memwrite,
                    mem_branch, mem_wreg};
    assign wb_g  = {wb_regwrite, wb_memtoreg, wb_wreg};
    assign ctl_g = {hold_pc, flush_ifid, jump_taken, branch_taken};
    assign all_g = {ex_g, mem_g, wb_g, ctl_g, stall_count};

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {regdst,jump,branch,memread,memtoreg,memwrite,alusrc,regwrite,aluop}
    function automatic logic [9:0] dec(input int k);
        case (k)
            K_ADD:   return 10'b10000001_00;
            K_LW:    return 10'b00011011_11;
            K_SW:    return 10'b00000110_11;
            K_ADDI:  return 10'b00000011_11;
            K_BEQ:   return 10'b00100000_01;
            K_J:     return 10'b01000000_00;
            default: return 10'b0;
        endcase
    endfunction

    function automatic logic [10:0] ex_e(input int k, input logic [4:0] w);
        case (k)
            K_ADD:   return {4'b1100, 2'b00, w};
            K_LW:    return {4'b1011, 2'b11, w};
            K_SW:    return {4'b1010, 2'b11, w};
            K_ADDI:  return {4'b1010, 2'b11, w};
            K_BEQ:   return {4'b1000, 2'b01, w};
            K_J:     return {4'b1000, 2'b00, w};
            default: return 11'b0;
        endcase
    endfunction

    function automatic logic [8:0] mem_e(input int k, input logic [4:0] w);
        case (k)
            K_ADD:   return {4'b1000, w};
            K_LW:    return {4'b1100, w};
            K_SW:    return {4'b1010, w};
            K_ADDI:  return {4'b1000, w};
            K_BEQ:   return {4'b1001, w};
            K_J:     return {4'b1000, w};
            default: return 9'b0;
        endcase
    endfunction

    function automatic logic [6:0] wb_e(input int k, input logic [4:0] w);
        case (k)
            K_ADD:   return {2'b10, w};
            K_LW:    return {2'b11, w};
            K_ADDI:  return {2'b10, w};
            K_SW, K_BEQ, K_J: return {2'b00, w};
            default: return 7'b0;
        endcase
    endfunction

    task automatic drive(input int k, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic mz);
        logic [9:0] d;
        d = dec(k);
        id_valid = (k != K_B);
        {regdst, jump, branch, memread,
         memtoreg, memwrite, alusrc, regwrite} = d[9:2];
        aluop    = d[1:0];
        id_rs    = rs;
        id_rt    = rt;
        id_rd    = rd;
        mem_zero = mz;
    endtask

    typedef struct {
        int k;
        logic [4:0] rs, rt, rd;
        logic mz;
        int ek; logic [4:0] ew;
        int mk; logic [4:0] mw;
        int wk; logic [4:0] ww;
        logic [3:0] ctl;
        logic [1:0] cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int k, input int rs, input int rt,
                       input int rd, input logic mz,
                       input int ek, input int ew,
                       input int mk, input int mw,
                       input int wk, input int ww,
                       input logic [3:0] ctl, input int cnt);
        vec_t v;
        v.k = k; v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd);
        v.mz = mz;
        v.ek = ek; v.ew = 5'(ew);
        v.mk = mk; v.mw = 5'(mw);
        v.wk = wk; v.ww = 5'(ww);
        v.ctl = ctl; v.cnt = 2'(cnt);
        vq.push_back(v);
    endtask

    int sat_exp[5];

    initial begin
        // load-use: lw r8 then add using r8
        add(K_LW,  1, 8, 0, 0, K_B, 0,  K_B, 0,  K_B, 0,  4'b0000, 0);
        add(K_ADD, 8, 2, 3, 0, K_LW, 8, K_B, 0,  K_B, 0,  4'b1000, 0);
        add(K_ADD, 8, 2, 3, 0, K_B, 0,  K_LW, 8, K_B, 0,  4'b0000, 1);
        add(K_B,   0, 0, 0, 0, K_ADD, 3, K_B, 0, K_LW, 8, 4'b0000, 1);
        add(K_B,   0, 0, 0, 0, K_B, 0,  K_ADD, 3, K_B, 0, 4'b0000, 1);
        // no hazard: rt=0 and unrelated registers
        add(K_LW,  1, 0, 0, 0, K_B, 0,  K_B, 0,  K_ADD, 3, 4'b0000, 1);
        add(K_ADD, 0, 0, 4, 0, K_LW, 0, K_B, 0,  K_B, 0,  4'b0000, 1);
        add(K_LW,  1, 8, 0, 0, K_ADD, 4, K_LW, 0, K_B, 0, 4'b0000, 1);
        add(K_ADDI, 9, 10, 0, 0, K_LW, 8, K_ADD, 4, K_LW, 0, 4'b0000, 1);
        add(K_B, 0, 0, 0, 0, K_ADDI, 10, K_LW, 8, K_ADD, 4, 4'b0000, 1);
        add(K_B, 0, 0, 0, 0, K_B, 0, K_ADDI, 10, K_LW, 8, 4'b0000, 1);
        add(K_B, 0, 0, 0, 0, K_B, 0, K_B, 0, K_ADDI, 10, 4'b0000, 1);
        // taken beq squashes sw and addi
        add(K_BEQ, 1, 2, 0, 0, K_B, 0,  K_B, 0,  K_B, 0,  4'b0000, 1);
        add(K_SW,  1, 5, 0, 0, K_BEQ, 2, K_B, 0, K_B, 0,  4'b0000, 1);
        add(K_ADDI, 1, 6, 0, 1, K_SW, 5, K_BEQ, 2, K_B, 0, 4'b0101, 1);
        add(K_B,   0, 0, 0, 1, K_B, 0,  K_B, 0,  K_BEQ, 2, 4'b0000, 1);
        add(K_B,   0, 0, 0, 0, K_B, 0,  K_B, 0,  K_B, 0,  4'b0000, 1);
        // jump stalled by load-use, taken one cycle later
        add(K_LW,  1, 7, 0, 0, K_B, 0,  K_B, 0,  K_B, 0,  4'b0000, 1);
        add(K_J,   7, 0, 0, 0, K_LW, 7, K_B, 0,  K_B, 0,  4'b1000, 1);
        add(K_J,   7, 0, 0, 0, K_B, 0,  K_LW, 7, K_B, 0,  4'b0110, 2);
        add(K_B,   0, 0, 0, 0, K_J, 0,  K_B, 0,  K_LW, 7, 4'b0000, 2);
        add(K_B,   0, 0, 0, 0, K_B, 0,  K_J, 0,  K_B, 0,  4'b0000, 2);
        add(K_B,   0, 0, 0, 0, K_B, 0,  K_B, 0,  K_J, 0,  4'b0000, 2);
        // branch taken together with load-use: flush wins
        add(K_BEQ, 1, 2, 0, 0, K_B, 0,  K_B, 0,  K_B, 0,  4'b0000, 2);
        add(K_LW,  1, 9, 0, 0, K_BEQ, 2, K_B, 0, K_B, 0,  4'b0000, 2);
        add(K_ADD, 9, 3, 4, 1, K_LW, 9, K_BEQ, 2, K_B, 0, 4'b0101, 2);
        add(K_B,   0, 0, 0, 0, K_B, 0,  K_B, 0,  K_BEQ, 2, 4'b0000, 2);

        sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3;
        sat_exp[3] = 3; sat_exp[4] = 3;

        rst_n = 1'b0;
        drive(K_B, 0, 0, 0, 0);
        #12;
        chk("reset_state", 64'(all_g), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].k, vq[i].rs, vq[i].rt, vq[i].rd, vq[i].mz);
            @(negedge clk);
            chk($sformatf("v%0d_ex", i), 64'(ex_g),
                64'(ex_e(vq[i].ek, vq[i].ew)));
            chk($sformatf("v%0d_mem", i), 64'(mem_g),
                64'(mem_e(vq[i].mk, vq[i].mw)));
            chk($sformatf("v%0d_wb", i), 64'(wb_g),
                64'(wb_e(vq[i].wk, vq[i].ww)));
            chk($sformatf("v%0d_ctl", i), 64'(ctl_g), 64'(vq[i].ctl));
            chk($sformatf("v%0d_cnt", i), 64'(stall_count),
                64'(vq[i].cnt));
            @(posedge clk); #1;
        end

        // asynchronous reset mid-stream with a load in EX
        drive(K_LW, 1, 8, 0, 0);
        @(posedge clk); #1;
        drive(K_ADD, 8, 2, 3, 0);
        chk("pre_rst_memread", 64'(ex_memread), 64'd1);
        chk("pre_rst_cnt", 64'(stall_count), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_all", 64'(all_g), 64'd0);
        @(posedge clk); #1;
        chk("rst_held_all", 64'(all_g), 64'd0);
        rst_n = 1'b1;
        drive(K_ADD, 1, 2, 3, 0);
        @(negedge clk);
        chk("rst_release_all", 64'(all_g), 64'd0);
        @(posedge clk); #1;
        chk("rst_first_ex", 64'(ex_g), 64'(ex_e(K_ADD, 5'd3)));

        // counter saturation with back-to-back hazards
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        drive(K_LW, 1, 8, 0, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            drive(K_LW, 8, 8, 0, 0);
            chk($sformatf("sat%0d_hold", i), 64'(hold_pc), 64'd1);
            @(posedge clk); #1;
            chk($sformatf("sat%0d_cnt", i), 64'(stall_count),
                64'(sat_exp[i]));
            chk($sformatf("sat%0d_free", i), 64'(hold_pc), 64'd0);
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
